rv32i_multicycle_ctrl: RTL and testbench
========================================

Name: rv32i_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared datapath: instruction register, PC, register file, ALU, immediate generator and the single memory port. It decodes the opcode from the instruction register, drives every datapath strobe and mux select, and counts retired instructions. It traps on illegal opcodes and on memory handshake timeouts.

Parameters:
MAX_WAIT, 255, maximum cycles spent waiting for i_mem_ready in FETCH or MEM before a bus-error trap (1..255; wait counter is 8 bits)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_instr  input  32  current instruction register contents (valid from DECODE onward)
i_mem_ready  input  1  memory port handshake complete this cycle
i_br_taken  input  1  branch comparator result, valid in EXEC
o_mem_req  output  1  memory access request
o_mem_we  output  1  memory write (store)
o_mem_addr_sel  output  1  0 = PC, 1 = ALU result
o_ir_we  output  1  load instruction register
o_pc_we  output  1  update PC
o_pc_sel  output  2  0 = PC+4, 1 = PC+imm, 2 = {ALU[31:1],1'b0}
o_rf_we  output  1  register file write
o_wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate
o_alu_a_sel  output  1  0 = rs1, 1 = PC
o_alu_b_imm  output  1  0 = rs2, 1 = immediate
o_illegal  output  1  trapped on illegal opcode (sticky)
o_bus_err  output  1  trapped on memory timeout (sticky)
o_instret  output  32  retired instruction count
o_state  output  3  current state encoding

Behaviour:
- States: RST=6, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. The state register, wait counter, o_instret, o_illegal and o_bus_err are flops. All other outputs are combinational from state and i_instr.
- Async reset: state=RST, o_instret=0, wait counter=0, o_illegal=0, o_bus_err=0. In RST every strobe and select output is 0. RST goes to FETCH unconditionally on the next edge.
- Default outputs in every state: all 0.
- FETCH: o_mem_req=1, o_mem_addr_sel=0. If i_mem_ready=1: o_ir_we=1 in the same cycle, next state DECODE, wait counter cleared. Otherwise the wait counter increments. When the count reaches MAX_WAIT without ready: go to TRAP and set o_bus_err.
- DECODE: one cycle, no strobes. Legal opcodes: 0000011 LOAD, 0010011 OP-IMM, 0100011 STORE, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 0110011 OP. Legal goes to EXEC. Any other opcode goes to TRAP and sets o_illegal.
- EXEC, per opcode; every non-memory case asserts o_pc_we, counts as a retirement and returns to FETCH:
  - OP: alu_b_imm=0, wb_sel=0, rf_we, pc_sel=0.
  - OP-IMM: alu_b_imm=1, wb_sel=0, rf_we, pc_sel=0.
  - LUI: wb_sel=3, rf_we, pc_sel=0.
  - AUIPC: alu_a_sel=1, alu_b_imm=1, wb_sel=0, rf_we, pc_sel=0.
  - JAL: wb_sel=2, rf_we, pc_sel=1.
  - JALR: alu_b_imm=1, wb_sel=2, rf_we, pc_sel=2.
  - BRANCH: pc_sel = i_br_taken ? 1 : 0.
  - LOAD/STORE: alu_b_imm=1, no strobes, go to MEM.
- MEM: o_mem_req=1, o_mem_addr_sel=1, o_alu_b_imm=1, o_mem_we=1 for STORE. Wait/timeout rules are identical to FETCH. On ready:
  - STORE: o_pc_we=1, pc_sel=0, retire, go to FETCH.
  - LOAD: go to WB.
- WB (LOAD only): rf_we, wb_sel=1, pc_we, pc_sel=0, retire, go to FETCH.
- rd = i_instr[11:7] = 0 forces o_rf_we=0; the instruction still retires and advances the PC.
- Retirement: o_instret increments by 1 on the edge ending the retiring cycle and wraps from 0xFFFFFFFF to 0.
- TRAP: absorbing state until reset. All strobes are 0, flags hold, o_instret holds.
- i_mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-access drops o_mem_req immediately; no retirement is counted for the interrupted instruction.
- Ready arriving on exactly the MAX_WAIT-th wait cycle is accepted, not trapped.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093), ready on first FETCH cycle -> states RST,FETCH,DECODE,EXEC; EXEC has rf_we=1, alu_b_imm=1, pc_we=1, pc_sel=0; o_instret=1.
- LW x2,0(x1) (0x0000A103) with ready delayed 3 cycles in MEM -> mem_req held 3+1 cycles with addr_sel=1; WB has wb_sel=1, rf_we=1; instret +1.
- BEQ with i_br_taken=1 then 0 -> EXEC pc_sel=1 then 0; rf_we=0 both; instret +2.
- ADDI x0,x0,1 (0x00100013) -> rf_we=0, pc_we=1, instret +1. JALR x1,0(x5) (0x000280E7) -> pc_sel=2, wb_sel=2, rf_we=1.
- Opcode 0x0000007F -> DECODE goes to TRAP, o_illegal=1, no strobes for 10 further cycles even with ready toggling; reset clears o_illegal.
- MAX_WAIT=4, ready never asserted in FETCH -> TRAP after 4 wait cycles, o_bus_err=1. Repeat with ready on cycle 4 -> DECODE, no error.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback
// over the shared datapath, counts retired instructions and traps on illegal opcodes or bus timeouts.
module rv32i_multicycle_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_mem_ready,
    input  logic        i_br_taken,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_mem_addr_sel,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic [1:0]  o_pc_sel,
    output logic        o_rf_we,
    output logic [1:0]  o_wb_sel,
    output logic        o_alu_a_sel,
    output logic        o_alu_b_imm,
    output logic        o_illegal,
    output logic        o_bus_err,
    output logic [31:0] o_instret,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_RST    = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // The wait counter holds the number of already-elapsed unready cycles, so the
    // last permitted wait cycle is the one entered with count MAX_WAIT-1.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] instret_reg;
    logic        illegal_reg, bus_err_reg;
    logic        retire, set_illegal, set_bus_err;
    logic        rf_we_raw;

    logic [6:0]  opcode;
    logic        rd_zero;
    logic        is_legal;
    logic        unused_instr_bits;

    assign opcode            = i_instr[6:0];
    assign rd_zero           = (i_instr[11:7] == 5'd0);
    assign unused_instr_bits = ^i_instr[31:12];

    always_comb begin
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP: is_legal = 1'b1;
            default:                              is_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= S_RST;
            wait_cnt_reg <= 8'd0;
            instret_reg  <= 32'd0;
            illegal_reg  <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (retire)
                instret_reg <= instret_reg + 32'd1;
            if (set_illegal)
                illegal_reg <= 1'b1;
            if (set_bus_err)
                bus_err_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = 8'd0;
        retire         = 1'b0;
        set_illegal    = 1'b0;
        set_bus_err    = 1'b0;
        rf_we_raw      = 1'b0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr_sel = 1'b0;
        o_ir_we        = 1'b0;
        o_pc_we        = 1'b0;
        o_pc_sel       = 2'd0;
        o_wb_sel       = 2'd0;
        o_alu_a_sel    = 1'b0;
        o_alu_b_imm    = 1'b0;

        case (state_reg)
            S_RST: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_we    = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next  = S_TRAP;
                    set_bus_err = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end

            S_DECODE: begin
                if (is_legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next  = S_TRAP;
                    set_illegal = 1'b1;
                end
            end

            S_EXEC: begin
                o_pc_we    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
                case (opcode)
                    OPC_OP: begin
                        rf_we_raw = 1'b1;
                    end
                    OPC_OPIMM: begin
                        o_alu_b_imm = 1'b1;
                        rf_we_raw   = 1'b1;
                    end
                    OPC_LUI: begin
                        o_wb_sel  = 2'd3;
                        rf_we_raw = 1'b1;
                    end
                    OPC_AUIPC: begin
                        o_alu_a_sel = 1'b1;
                        o_alu_b_imm = 1'b1;
                        rf_we_raw   = 1'b1;
                    end
                    OPC_JAL: begin
                        o_wb_sel  = 2'd2;
                        o_pc_sel  = 2'd1;
                        rf_we_raw = 1'b1;
                    end
                    OPC_JALR: begin
                        o_alu_b_imm = 1'b1;
                        o_wb_sel    = 2'd2;
                        o_pc_sel    = 2'd2;
                        rf_we_raw   = 1'b1;
                    end
                    OPC_BRANCH: begin
                        o_pc_sel = i_br_taken ? 2'd1 : 2'd0;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        // Address computation only; the access itself happens in MEM.
                        o_alu_b_imm = 1'b1;
                        o_pc_we     = 1'b0;
                        retire      = 1'b0;
                        state_next  = S_MEM;
                    end
                    default: begin
                        // IR changed under us after DECODE: treat as illegal rather than guess.
                        o_pc_we     = 1'b0;
                        retire      = 1'b0;
                        state_next  = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                o_mem_req      = 1'b1;
                o_mem_addr_sel = 1'b1;
                o_alu_b_imm    = 1'b1;
                o_mem_we       = (opcode == OPC_STORE);
                if (i_mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        o_pc_we    = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next  = S_TRAP;
                    set_bus_err = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end

            S_WB: begin
                rf_we_raw  = 1'b1;
                o_wb_sel   = 2'd1;
                o_pc_we    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_TRAP: begin
                state_next = S_TRAP;
            end

            default: begin
                state_next = S_RST;
            end
        endcase
    end

    // Writes to x0 are suppressed here so the register file never sees them.
    assign o_rf_we   = rf_we_raw & ~rd_zero;
    assign o_illegal = illegal_reg;
    assign o_bus_err = bus_err_reg;
    assign o_instret = instret_reg;
    assign o_state   = state_reg;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl: a per-cycle vector table for the main
// instruction mix plus hand-written sequences for traps, timeouts and mid-access reset.
module tb_rv32i_multicycle_ctrl;

    localparam int MW = 4;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DEC = 3'd1, ST_EXEC = 3'd2,
                           ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5, ST_RST = 3'd6;

    localparam logic [31:0] I_ADDI    = 32'h00500093;
    localparam logic [31:0] I_LW      = 32'h0000A103;
    localparam logic [31:0] I_BEQ     = 32'h00000463;
    localparam logic [31:0] I_ADDI_X0 = 32'h00100013;
    localparam logic [31:0] I_JALR    = 32'h000280E7;
    localparam logic [31:0] I_SW      = 32'h0020A223;
    localparam logic [31:0] I_LUI     = 32'h123451B7;
    localparam logic [31:0] I_JAL     = 32'h008000EF;
    localparam logic [31:0] I_ADD     = 32'h002081B3;
    localparam logic [31:0] I_AUIPC   = 32'h00001217;
    localparam logic [31:0] I_BAD     = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        ready = 1'b0;
    logic        br = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, alu_a_sel, alu_b_imm;
    logic [1:0]  pc_sel, wb_sel;
    logic        illegal, bus_err;
    logic [31:0] instret;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rv32i_multicycle_ctrl #(.MAX_WAIT(MW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_mem_ready(ready),
        .i_br_taken(br), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr_sel(mem_addr_sel), .o_ir_we(ir_we), .o_pc_we(pc_we),
        .o_pc_sel(pc_sel), .o_rf_we(rf_we), .o_wb_sel(wb_sel),
        .o_alu_a_sel(alu_a_sel), .o_alu_b_imm(alu_b_imm), .o_illegal(illegal),
        .o_bus_err(bus_err), .o_instret(instret), .o_state(state)
    );

    // Control bundle: {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel, a_sel, b_imm}
    function automatic logic [11:0] mk(input logic mr, input logic mw, input logic as_,
                                       input logic ir, input logic pw, input logic [1:0] ps,
                                       input logic rw, input logic [1:0] ws,
                                       input logic a, input logic b);
        return {mr, mw, as_, ir, pw, ps, rw, ws, a, b};
    endfunction

    logic [11:0] act_ctl;
    assign act_ctl = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                      alu_a_sel, alu_b_imm};

    localparam logic [11:0] K0 = 12'd0;
    logic [11:0] k_fetch, k_fetch_r, k_addi, k_ls_ex, k_ld_mem, k_wb, k_br_t, k_br_n,
                 k_addi_x0, k_jalr, k_st_mem_r, k_lui, k_jal, k_op, k_auipc;

    typedef struct {
        logic [31:0] instr;
        logic        ready;
        logic        br;
        logic [2:0]  st;
        logic [11:0] ctl;
        logic [31:0] instret;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] i, input logic r, input logic b, input logic [2:0] s,
                       input logic [11:0] c, input logic [31:0] n);
        vec_t v;
        v.instr = i; v.ready = r; v.br = b; v.st = s; v.ctl = c; v.instret = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive on the falling edge, sample 1 time unit later.
    task automatic step(input string name, input logic [31:0] i, input logic r, input logic b,
                        input logic [2:0] s, input logic [11:0] c, input logic [31:0] n,
                        input logic [1:0] flags);
        @(negedge clk);
        instr = i; ready = r; br = b;
        #1;
        chk({name, " state"}, 32'(state), 32'(s));
        chk({name, " ctl"}, 32'(act_ctl), 32'(c));
        chk({name, " instret"}, instret, n);
        chk({name, " flags"}, 32'({illegal, bus_err}), 32'(flags));
        $display("[TB] %s: state=%0d ctl=%h instret=%0d ill=%0b berr=%0b",
                 name, state, act_ctl, instret, illegal, bus_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ready = 1'b0; br = 1'b0;
        #1;
        chk("reset state", 32'(state), 32'(ST_RST));
        chk("reset ctl", 32'(act_ctl), 32'(K0));
        chk("reset instret", instret, 32'd0);
        chk("reset flags", 32'({illegal, bus_err}), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        k_fetch    = mk(1,0,0,0,0,2'd0,0,2'd0,0,0);
        k_fetch_r  = mk(1,0,0,1,0,2'd0,0,2'd0,0,0);
        k_addi     = mk(0,0,0,0,1,2'd0,1,2'd0,0,1);
        k_ls_ex    = mk(0,0,0,0,0,2'd0,0,2'd0,0,1);
        k_ld_mem   = mk(1,0,1,0,0,2'd0,0,2'd0,0,1);
        k_wb       = mk(0,0,0,0,1,2'd0,1,2'd1,0,0);
        k_br_t     = mk(0,0,0,0,1,2'd1,0,2'd0,0,0);
        k_br_n     = mk(0,0,0,0,1,2'd0,0,2'd0,0,0);
        k_addi_x0  = mk(0,0,0,0,1,2'd0,0,2'd0,0,1);
        k_jalr     = mk(0,0,0,0,1,2'd2,1,2'd2,0,1);
        k_st_mem_r = mk(1,1,1,0,1,2'd0,0,2'd0,0,1);
        k_lui      = mk(0,0,0,0,1,2'd0,1,2'd3,0,0);
        k_jal      = mk(0,0,0,0,1,2'd1,1,2'd2,0,0);
        k_op       = mk(0,0,0,0,1,2'd0,1,2'd0,0,0);
        k_auipc    = mk(0,0,0,0,1,2'd0,1,2'd0,1,1);

        // ADDI x1,x0,5
        add(I_ADDI, 0, 0, ST_RST,   K0,        0);
        add(I_ADDI, 1, 0, ST_FETCH, k_fetch_r, 0);
        add(I_ADDI, 1, 0, ST_DEC,   K0,        0);
        add(I_ADDI, 0, 0, ST_EXEC,  k_addi,    0);
        // LW x2,0(x1), ready on the 4th MEM cycle (MAX_WAIT-th: accepted)
        add(I_LW,   1, 0, ST_FETCH, k_fetch_r, 1);
        add(I_LW,   0, 0, ST_DEC,   K0,        1);
        add(I_LW,   1, 0, ST_EXEC,  k_ls_ex,   1);
        add(I_LW,   0, 0, ST_MEM,   k_ld_mem,  1);
        add(I_LW,   0, 0, ST_MEM,   k_ld_mem,  1);
        add(I_LW,   0, 0, ST_MEM,   k_ld_mem,  1);
        add(I_LW,   1, 0, ST_MEM,   k_ld_mem,  1);
        add(I_LW,   1, 0, ST_WB,    k_wb,      1);
        // BEQ taken, then not taken
        add(I_BEQ,  1, 0, ST_FETCH, k_fetch_r, 2);
        add(I_BEQ,  0, 0, ST_DEC,   K0,        2);
        add(I_BEQ,  0, 1, ST_EXEC,  k_br_t,    2);
        add(I_BEQ,  1, 0, ST_FETCH, k_fetch_r, 3);
        add(I_BEQ,  0, 1, ST_DEC,   K0,        3);
        add(I_BEQ,  0, 0, ST_EXEC,  k_br_n,    3);
        // ADDI x0,x0,1
        add(I_ADDI_X0, 1, 0, ST_FETCH, k_fetch_r, 4);
        add(I_ADDI_X0, 0, 0, ST_DEC,   K0,        4);
        add(I_ADDI_X0, 0, 0, ST_EXEC,  k_addi_x0, 4);
        // JALR x1,0(x5)
        add(I_JALR, 1, 0, ST_FETCH, k_fetch_r, 5);
        add(I_JALR, 0, 0, ST_DEC,   K0,        5);
        add(I_JALR, 0, 0, ST_EXEC,  k_jalr,    5);
        // SW x2,4(x1), one FETCH wait
        add(I_SW,   0, 0, ST_FETCH, k_fetch,   6);
        add(I_SW,   1, 0, ST_FETCH, k_fetch_r, 6);
        add(I_SW,   0, 0, ST_DEC,   K0,        6);
        add(I_SW,   0, 0, ST_EXEC,  k_ls_ex,   6);
        add(I_SW,   1, 0, ST_MEM,   k_st_mem_r,6);
        // LUI x3
        add(I_LUI,  1, 0, ST_FETCH, k_fetch_r, 7);
        add(I_LUI,  0, 0, ST_DEC,   K0,        7);
        add(I_LUI,  0, 0, ST_EXEC,  k_lui,     7);
        // JAL x1,8
        add(I_JAL,  1, 0, ST_FETCH, k_fetch_r, 8);
        add(I_JAL,  0, 0, ST_DEC,   K0,        8);
        add(I_JAL,  0, 0, ST_EXEC,  k_jal,     8);
        // ADD x3,x1,x2
        add(I_ADD,  1, 0, ST_FETCH, k_fetch_r, 9);
        add(I_ADD,  0, 0, ST_DEC,   K0,        9);
        add(I_ADD,  0, 0, ST_EXEC,  k_op,      9);
        // AUIPC x4,1
        add(I_AUIPC,1, 0, ST_FETCH, k_fetch_r, 10);
        add(I_AUIPC,0, 0, ST_DEC,   K0,        10);
        add(I_AUIPC,0, 0, ST_EXEC,  k_auipc,   10);
        add(I_AUIPC,0, 0, ST_FETCH, k_fetch,   11);

        do_reset();
        foreach (vecs[i])
            step($sformatf("vec%0d", i), vecs[i].instr, vecs[i].ready, vecs[i].br,
                 vecs[i].st, vecs[i].ctl, vecs[i].instret, 2'b00);

        // Illegal opcode: trap, stay quiet with ready toggling, reset clears the flag
        do_reset();
        step("ill rst",    I_BAD, 1, 0, ST_RST,   K0,        0, 2'b00);
        step("ill fetch",  I_BAD, 1, 0, ST_FETCH, k_fetch_r, 0, 2'b00);
        step("ill decode", I_BAD, 0, 0, ST_DEC,   K0,        0, 2'b00);
        for (int i = 0; i < 10; i++)
            step($sformatf("ill trap%0d", i), I_BAD, 1'(i), 1'(i), ST_TRAP, K0, 0, 2'b10);
        do_reset();

        // FETCH timeout after MAX_WAIT unready cycles
        step("fto rst", I_ADDI, 0, 0, ST_RST, K0, 0, 2'b00);
        for (int i = 1; i <= MW; i++)
            step($sformatf("fto wait%0d", i), I_ADDI, 0, 0, ST_FETCH, k_fetch, 0, 2'b00);
        step("fto trap0", I_ADDI, 1, 0, ST_TRAP, K0, 0, 2'b01);
        step("fto trap1", I_ADDI, 1, 0, ST_TRAP, K0, 0, 2'b01);

        // Ready on the MAX_WAIT-th FETCH cycle is accepted; then MEM timeout on LW
        do_reset();
        step("f4 rst", I_LW, 0, 0, ST_RST, K0, 0, 2'b00);
        for (int i = 1; i < MW; i++)
            step($sformatf("f4 wait%0d", i), I_LW, 0, 0, ST_FETCH, k_fetch, 0, 2'b00);
        step("f4 accept", I_LW, 1, 0, ST_FETCH, k_fetch_r, 0, 2'b00);
        step("f4 decode", I_LW, 0, 0, ST_DEC,   K0,        0, 2'b00);
        step("f4 exec",   I_LW, 0, 0, ST_EXEC,  k_ls_ex,   0, 2'b00);
        for (int i = 1; i <= MW; i++)
            step($sformatf("mto wait%0d", i), I_LW, 0, 0, ST_MEM, k_ld_mem, 0, 2'b00);
        step("mto trap", I_LW, 1, 0, ST_TRAP, K0, 0, 2'b01);

        // Reset in the middle of a MEM access: request drops at once, nothing retires
        do_reset();
        step("mid rst",    I_LW, 0, 0, ST_RST,   K0,        0, 2'b00);
        step("mid fetch",  I_LW, 1, 0, ST_FETCH, k_fetch_r, 0, 2'b00);
        step("mid decode", I_LW, 0, 0, ST_DEC,   K0,        0, 2'b00);
        step("mid exec",   I_LW, 0, 0, ST_EXEC,  k_ls_ex,   0, 2'b00);
        step("mid mem",    I_LW, 1, 0, ST_MEM,   k_ld_mem,  0, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("mid async mem_req", 32'(mem_req), 32'd0);
        chk("mid async state", 32'(state), 32'(ST_RST));
        $display("[TB] mid async reset: mem_req=%0b state=%0d", mem_req, state);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step("post rst",    I_ADDI, 0, 0, ST_RST,   K0,        0, 2'b00);
        step("post fetch",  I_ADDI, 1, 0, ST_FETCH, k_fetch_r, 0, 2'b00);
        step("post decode", I_ADDI, 0, 0, ST_DEC,   K0,        0, 2'b00);
        step("post exec",   I_ADDI, 0, 0, ST_EXEC,  k_addi,    0, 2'b00);
        step("post fetch2", I_ADDI, 0, 0, ST_FETCH, k_fetch,   1, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
